// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register family: shift/rotate modes and burst FSM states.
// Also consumed by the existing register testbenches, so the values must stay stable.
package shift_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit 0 of a mode selects direction (1 = right); bit 1 selects rotate versus fill.
    function automatic logic mode_is_right(input logic [1:0] mode);
        return mode[0];
    endfunction

    function automatic logic mode_is_rotate(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational one-step shift/rotate of a WIDTH-bit word.
// The bit entering at the vacated end is serial_in for shifts, or the bit leaving at the other end for rotates.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [1:0]       i_mode,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] o_q
);

    logic             w_right;
    logic             w_fill_lsb;
    logic             w_fill_msb;
    logic [WIDTH-1:0] w_left_q;
    logic [WIDTH-1:0] w_right_q;

    assign w_right    = mode_is_right(i_mode);
    assign w_fill_lsb = mode_is_rotate(i_mode) ? i_q[WIDTH-1] : i_serial_in;
    assign w_fill_msb = mode_is_rotate(i_mode) ? i_q[0]       : i_serial_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign w_left_q[gi] = w_fill_lsb;
            end else begin : g_lsb_n
                assign w_left_q[gi] = i_q[gi-1];
            end

            if (gi == WIDTH - 1) begin : g_msb
                assign w_right_q[gi] = w_fill_msb;
            end else begin : g_msb_n
                assign w_right_q[gi] = i_q[gi+1];
            end

            assign o_q[gi] = w_right ? w_right_q[gi] : w_left_q[gi];
        end
    endgenerate

endmodule

// File: rtl/shift_register_burst.sv
// Parallel-load shift register with a burst engine: one start command performs N shifts/rotates.
// A load aborts a running burst; an asynchronous reset discards it without a done pulse.
module shift_register_burst
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] shift_count,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic [1:0]       w_eff_mode;
    logic             w_busy;

    assign w_busy = (r_state == ST_SHIFT);

    shift_unit #(
        .WIDTH(WIDTH)
    ) u_shift_unit (
        .i_q        (r_q),
        .i_mode     (r_mode),
        .i_serial_in(serial_in),
        .o_q        (w_shifted)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_SHL;
            r_count <= CNT_ZERO;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_q <= parallel_in;
                    end else if (start) begin
                        if (shift_count == CNT_ZERO) begin
                            r_done <= 1'b1;
                        end else begin
                            r_mode  <= mode;
                            r_count <= shift_count;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // A load wins over the pending shift and silently ends the burst.
                    if (load) begin
                        r_q     <= parallel_in;
                        r_count <= CNT_ZERO;
                        r_state <= ST_IDLE;
                    end else begin
                        r_q     <= w_shifted;
                        r_count <= r_count - CNT_ONE;
                        if (r_count == CNT_ONE) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // In IDLE the caller's mode input predicts which end the next burst will drain.
    assign w_eff_mode = w_busy ? r_mode : mode;
    assign serial_out = mode_is_right(w_eff_mode) ? r_q[0] : r_q[WIDTH-1];

    assign q    = r_q;
    assign busy = w_busy;
    assign done = r_done;

endmodule

// File: tb/tb_shift_register_burst.sv
// Self-checking bench for shift_register_burst (WIDTH=8): directed scenarios plus randomized bursts
// compared against an arithmetic model of the shift/rotate rules.
module tb_shift_register_burst;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] parallel_in;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] shift_count;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    int total;
    int bad;

    shift_register_burst #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .parallel_in(parallel_in),
        .start      (start),
        .mode       (mode),
        .shift_count(shift_count),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next value of an 8-bit register after one operation, from plain arithmetic.
    function automatic logic [7:0] ref_shift(input logic [7:0] v, input int m, input logic s);
        int x;
        x = int'(v);
        case (m)
            0:       x = (x * 2 + int'(s)) % 256;
            1:       x = x / 2 + int'(s) * 128;
            2:       x = (x * 2) % 256 + x / 128;
            default: x = x / 2 + (x % 2) * 128;
        endcase
        return 8'(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        parallel_in = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        load = 1'b0; parallel_in = '0; start = 1'b0; mode = 2'b00;
        shift_count = '0; serial_in = 1'b0;
        tick();
        tick();
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || serial_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: got q=%h busy=%b done=%b so=%b want q=00 busy=0 done=0 so=0",
                     q, busy, done, serial_out);
        end
        #3 rst = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_shift_left_fill();
        logic [7:0] want [3] = '{8'h4B, 8'h97, 8'h2F};
        do_load(8'hA5);
        mode = 2'b00; shift_count = 4'd3; serial_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL shl_busy[%0d]: got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            tick();
            total++;
            if (q !== want[i]) begin
                bad++;
                $display("FAIL shl_q[%0d]: got %h want %h", i, q, want[i]);
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h2F) begin
            bad++;
            $display("FAIL shl_done: got done=%b busy=%b q=%h want done=1 busy=0 q=2f", done, busy, q);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL shl_done_pulse: got done=%b want 0", done);
        end
        $display("shift-left burst A5 x3 -> %h", q);
    endtask

    task automatic test_rotate_right_serial_out();
        logic exp_so [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_load(8'hA5);
        mode = 2'b11; shift_count = 4'd4; serial_in = 1'b0; start = 1'b1;
        total++;
        if (serial_out !== 1'b1) begin
            bad++;
            $display("FAIL ror_so_idle: got %b want 1", serial_out);
        end
        tick();
        start = 1'b0;
        mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (serial_out !== exp_so[i]) begin
                bad++;
                $display("FAIL ror_so[%0d]: got %b want %b", i, serial_out, exp_so[i]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || q !== 8'h5A) begin
            bad++;
            $display("FAIL ror_done: got done=%b q=%h want done=1 q=5a", done, q);
        end
        tick();
        $display("rotate-right burst A5 x4 -> %h", q);
    endtask

    task automatic test_zero_count();
        do_load(8'hA5);
        mode = 2'b00; shift_count = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || q !== 8'hA5) begin
            bad++;
            $display("FAIL zero_cnt: got busy=%b done=%b q=%h want busy=0 done=1 q=a5", busy, done, q);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'hA5) begin
            bad++;
            $display("FAIL zero_cnt_after: got busy=%b done=%b q=%h want busy=0 done=0 q=a5",
                     busy, done, q);
        end
        $display("zero-count burst -> %h", q);
    endtask

    task automatic test_load_abort();
        do_load(8'hA5);
        mode = 2'b10; shift_count = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (q !== 8'h96 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_mid: got q=%h busy=%b want q=96 busy=1", q, busy);
        end
        load = 1'b1; parallel_in = 8'h3C;
        tick();
        load = 1'b0;
        total++;
        if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort: got q=%h busy=%b done=%b want q=3c busy=0 done=0", q, busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h3C) begin
                bad++;
                $display("FAIL abort_quiet[%0d]: got q=%h busy=%b done=%b want q=3c busy=0 done=0",
                         i, q, busy, done);
            end
        end
        $display("load abort during rotate-left -> %h", q);
    endtask

    task automatic test_async_reset_mid_burst();
        do_load(8'hFF);
        mode = 2'b01; shift_count = 4'd6; serial_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        total++;
        if (q !== 8'h1F || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: got q=%h busy=%b want q=1f busy=1", q, busy);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got q=%h busy=%b done=%b want q=00 busy=0 done=0", q, busy, done);
        end
        #1 rst = 1'b1;
        tick();
        mode = 2'b00; shift_count = 4'd2; serial_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: got q=%h done=%b busy=%b want q=03 done=1 busy=0", q, done, busy);
        end
        tick();
        $display("async reset mid-burst, restart -> %h", q);
    endtask

    task automatic test_back_to_back();
        load = 1'b1; start = 1'b1; parallel_in = 8'h81; mode = 2'b00; shift_count = 4'd3;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        total++;
        if (q !== 8'h81 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL load_prio: got q=%h busy=%b done=%b want q=81 busy=0 done=0", q, busy, done);
        end
        mode = 2'b00; shift_count = 4'd5; serial_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                start = 1'b1; shift_count = 4'd1; mode = 2'b11;
            end else begin
                start = 1'b0;
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL b2b_busy[%0d]: got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            tick();
        end
        start = 1'b0;
        total++;
        if (q !== 8'h20 || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got q=%h done=%b busy=%b want q=20 done=1 busy=0", q, done, busy);
        end
        tick();
        $display("start ignored during burst -> %h", q);
    endtask

    task automatic test_random_bursts(input int n_bursts);
        logic [7:0] v;
        logic [7:0] exp_q;
        logic       exp_so;
        int         m;
        int         n;
        for (int k = 0; k < n_bursts; k++) begin
            v = 8'($urandom);
            m = int'($urandom_range(0, 3));
            n = int'($urandom_range(0, 15));
            do_load(v);
            total++;
            if (q !== v) begin
                bad++;
                $display("FAIL rnd_load[%0d]: got %h want %h", k, q, v);
            end
            mode = 2'(m); shift_count = 4'(n); start = 1'b1;
            tick();
            start = 1'b0;
            exp_q = v;
            for (int i = 0; i < n; i++) begin
                mode = 2'($urandom);
                shift_count = 4'($urandom);
                start = 1'($urandom);
                serial_in = 1'($urandom);
                exp_so = (m % 2 == 1) ? exp_q[0] : exp_q[7];
                total++;
                if (busy !== 1'b1 || done !== 1'b0 || q !== exp_q || serial_out !== exp_so) begin
                    bad++;
                    $display("FAIL rnd_step[%0d.%0d]: got q=%h busy=%b done=%b so=%b want q=%h busy=1 done=0 so=%b",
                             k, i, q, busy, done, serial_out, exp_q, exp_so);
                end
                tick();
                exp_q = ref_shift(exp_q, m, serial_in);
            end
            start = 1'b0;
            total++;
            if (busy !== 1'b0 || done !== 1'b1 || q !== exp_q) begin
                bad++;
                $display("FAIL rnd_done[%0d]: got q=%h busy=%b done=%b want q=%h busy=0 done=1",
                         k, q, busy, done, exp_q);
            end
            tick();
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || q !== exp_q) begin
                bad++;
                $display("FAIL rnd_idle[%0d]: got q=%h busy=%b done=%b want q=%h busy=0 done=0",
                         k, q, busy, done, exp_q);
            end
            $display("burst %0d: load=%h mode=%0d count=%0d -> q=%h", k, v, m, n, q);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_shift_left_fill();
        test_rotate_right_serial_out();
        test_zero_count();
        test_load_abort();
        test_async_reset_mid_burst();
        test_back_to_back();
        test_random_bursts(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
